// File: rtl/byte_queue_if.sv
// byte_queue_if
//  Bundles the deserializer-side capture handshake and the consumer-side
//  dequeue/status signals of the byte queue.
//  Parameters: DATA_W (byte width), DEPTH (entries, power of two >= 2).
//  Signals:
//    data_in        byte from deserializer, valid while data_ready_in=1
//    data_ready_in  level request, held by the deserializer until acknowledged
//    ack_out        one-cycle acknowledge of an accepted byte
//    dequeue_in     pop request, sampled every rising edge
//    data_out       last popped byte (registered)
//    len_out        occupancy 0..DEPTH
//    full_out       occupancy == DEPTH (registered)
//    empty_out      occupancy == 0 (registered)
//    overflow_out   sticky error flag, present only with QUEUE_ERR_FLAGS_EN
//    underflow_out  sticky error flag, present only with QUEUE_ERR_FLAGS_EN
//  Modports: master = deserializer/consumer side, slave = the queue.
//  Optional feature macro: QUEUE_ERR_FLAGS_EN.
interface byte_queue_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] data_in;
  logic              data_ready_in;
  logic              ack_out;
  logic              dequeue_in;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W:0]   len_out;
  logic              full_out;
  logic              empty_out;
`ifdef QUEUE_ERR_FLAGS_EN
  logic              overflow_out;
  logic              underflow_out;
`endif

  modport master (
    output data_in, data_ready_in, dequeue_in,
    input  ack_out, data_out, len_out, full_out, empty_out
`ifdef QUEUE_ERR_FLAGS_EN
    , input overflow_out, underflow_out
`endif
  );

  modport slave (
    input  data_in, data_ready_in, dequeue_in,
    output ack_out, data_out, len_out, full_out, empty_out
`ifdef QUEUE_ERR_FLAGS_EN
    , output overflow_out, underflow_out
`endif
  );
endinterface

// File: rtl/byte_queue.sv
// byte_queue
//  Byte FIFO sitting directly behind the serial deserializer. Each assembled
//  byte is captured through the data_ready_in/ack_out handshake and
//  acknowledged so the deserializer can rearm; bytes are handed out one per
//  dequeue request.
//  Ports:
//    clock_10KHZ  single clock, all logic on the rising edge
//    reset        asynchronous, active-low
//    bus          byte_queue_if.slave (handshake, dequeue and status signals)
//  Parameters: DATA_W (byte width), DEPTH (power of two >= 2).
//  Optional feature macro: QUEUE_ERR_FLAGS_EN adds the sticky overflow_out and
//  underflow_out flags; without it those ports and their logic are absent.
module byte_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic         clock_10KHZ,
  input  logic         reset,
  byte_queue_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count, count_nxt;
  logic              full_q, empty_q, ack_q;
  logic [DATA_W-1:0] data_q;
  logic              wr_en, rd_en;

  // Enqueue handshake: capture in IDLE, one ACK cycle, then DRAIN until the
  // deserializer drops its request so one held byte is never captured twice.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        // full_q is registered, so a pop on this same edge does not yet
        // make room; the request is taken on the following edge.
        if (bus.data_ready_in && !full_q) begin
          wr_en   = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     state_d = DRAIN;
      DRAIN:   if (!bus.data_ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rd_en = bus.dequeue_in && !empty_q;

  always_comb begin
    count_nxt = count;
    case ({wr_en, rd_en})
      2'b10:   count_nxt = count + ONE_CNT;
      2'b01:   count_nxt = count - ONE_CNT;
      default: count_nxt = count;
    endcase
  end

  // Control and output registers; flags are derived from the next count so
  // they line up with len_out.
  always_ff @(posedge clock_10KHZ or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ack_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= wr_en;
      count   <= count_nxt;
      full_q  <= (count_nxt == FULL_CNT);
      empty_q <= (count_nxt == '0);
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        data_q <= mem[rd_ptr];
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clock_10KHZ) begin
    if (wr_en) mem[wr_ptr] <= bus.data_in;
  end

  assign bus.ack_out   = ack_q;
  assign bus.data_out  = data_q;
  assign bus.len_out   = count;
  assign bus.full_out  = full_q;
  assign bus.empty_out = empty_q;

`ifdef QUEUE_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clock_10KHZ or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.data_ready_in && full_q) overflow_q <= 1'b1;
      if (bus.dequeue_in && empty_q) underflow_q <= 1'b1;
    end
  end

  assign bus.overflow_out  = overflow_q;
  assign bus.underflow_out = underflow_q;
`endif
endmodule
